// File: rtl/board_state_pkg.sv
// Shared chess definitions: piece codes, board geometry, FSM state encoding and layout helpers.
// Imported by board_state, its layout sub-module, the renderer and the game-control FSM.
package board_state_pkg;

   localparam int BOARD_DIM  = 8;
   localparam int CELL_IDX_W = 6;

   localparam logic [3:0] PIECE_EMPTY    = 4'd0;
   localparam logic [3:0] PIECE_B_PAWN   = 4'd1;
   localparam logic [3:0] PIECE_B_KNIGHT = 4'd2;
   localparam logic [3:0] PIECE_B_BISHOP = 4'd3;
   localparam logic [3:0] PIECE_B_ROOK   = 4'd4;
   localparam logic [3:0] PIECE_B_QUEEN  = 4'd5;
   localparam logic [3:0] PIECE_B_KING   = 4'd6;
   localparam logic [3:0] PIECE_W_PAWN   = 4'd7;
   localparam logic [3:0] PIECE_W_KNIGHT = 4'd8;
   localparam logic [3:0] PIECE_W_BISHOP = 4'd9;
   localparam logic [3:0] PIECE_W_ROOK   = 4'd10;
   localparam logic [3:0] PIECE_W_QUEEN  = 4'd11;
   localparam logic [3:0] PIECE_W_KING   = 4'd12;

   // White codes are the black codes shifted by this amount.
   localparam logic [3:0] WHITE_OFFSET   = 4'd6;

   typedef enum logic [2:0] {
      S_FILL,
      S_IDLE,
      S_MV_LATCH,
      S_MV_WRITE,
      S_MV_SETTLE,
      S_MV_DONE
   } state_t;

   function automatic logic [3:0] back_rank_piece(input logic [2:0] x);
      logic [3:0] code;
      case (x)
         3'd0, 3'd7: code = PIECE_B_ROOK;
         3'd1, 3'd6: code = PIECE_B_KNIGHT;
         3'd2, 3'd5: code = PIECE_B_BISHOP;
         3'd3:       code = PIECE_B_QUEEN;
         default:    code = PIECE_B_KING;
      endcase
      return code;
   endfunction

   function automatic logic is_king(input logic [3:0] code);
      return (code == PIECE_B_KING) || (code == PIECE_W_KING);
   endfunction

endpackage

// File: rtl/board_state_if.sv
// Board-state bus: renderer read port, control read port, layout reload and move-commit handshake.
// master = renderer/control side, slave = board_state.
interface board_state_if;
   logic       init_start;
   logic [2:0] view_x;
   logic [2:0] view_y;
   logic [3:0] piece_read;
   logic [2:0] q_x;
   logic [2:0] q_y;
   logic [3:0] q_piece;
   logic       move_valid;
   logic [2:0] src_x;
   logic [2:0] src_y;
   logic [2:0] dst_x;
   logic [2:0] dst_y;
   logic       move_ready;
   logic       move_done;
   logic [3:0] captured;
   logic       king_captured;
   logic       busy;

   modport master (
      output init_start, view_x, view_y, q_x, q_y,
      output move_valid, src_x, src_y, dst_x, dst_y,
      input  piece_read, q_piece, move_ready, move_done, captured, king_captured, busy
   );

   modport slave (
      input  init_start, view_x, view_y, q_x, q_y,
      input  move_valid, src_x, src_y, dst_x, dst_y,
      output piece_read, q_piece, move_ready, move_done, captured, king_captured, busy
   );
endinterface

// File: rtl/board_state_opening_layout.sv
// opening_layout: combinational map from cell index {y, x} to the standard opening piece code.
// Zero latency, no handshake.
module opening_layout
   import board_state_pkg::*;
(
   input  logic [5:0] idx,
   output logic [3:0] code
);

   logic [2:0] x;
   logic [2:0] y;

   assign x = idx[2:0];
   assign y = idx[5:3];

   always_comb begin
      code = PIECE_EMPTY;
      case (y)
         3'd0:    code = back_rank_piece(x);
         3'd1:    code = PIECE_B_PAWN;
         3'd6:    code = PIECE_W_PAWN;
         3'd7:    code = back_rank_piece(x) + WHITE_OFFSET;
         default: code = PIECE_EMPTY;
      endcase
   end

endmodule

// File: rtl/board_state.sv
// board_state: 64x4b piece store with opening fill and move commit; move_done 3+MOVE_SETTLE cycles after accept, moves held off by move_ready.
// Optional BOARD_STATE_PROMOTION_EN: pawns reaching the far rank are stored as queens.
module board_state
   import board_state_pkg::*;
#(
   parameter int FILL_PER_CYCLE = 1,
   parameter int MOVE_SETTLE    = 0
)(
   input  logic         clk,
   input  logic         reset,
   board_state_if.slave bus
);

   localparam logic [5:0] FILL_LAST   = 6'(64 / FILL_PER_CYCLE - 1);
   localparam logic [1:0] SETTLE_LAST = 2'(MOVE_SETTLE - 1);

   state_t     state;
   state_t     state_nxt;
   logic [3:0] cells [64];
   logic [5:0] fill_cnt;
   logic [1:0] settle_cnt;
   logic [5:0] src_idx;
   logic [5:0] dst_idx;
   logic [3:0] captured_next;
   logic [3:0] captured_r;
   logic       king_r;
   logic [3:0] move_code;
   logic       fill_last;
   logic       settle_last;

   logic [5:0] lay_idx  [FILL_PER_CYCLE];
   logic [3:0] lay_code [FILL_PER_CYCLE];

   // One layout lookup per cell written this cycle; a full row when filling 8 at a time.
   for (genvar k = 0; k < FILL_PER_CYCLE; k++) begin : g_fill
      if (FILL_PER_CYCLE == 8) begin : g_row
         assign lay_idx[k] = {fill_cnt[2:0], 3'(k)};
      end else begin : g_cell
         assign lay_idx[k] = fill_cnt;
      end
      opening_layout u_layout (
         .idx  (lay_idx[k]),
         .code (lay_code[k])
      );
   end

   assign fill_last   = (fill_cnt == FILL_LAST);
   assign settle_last = (settle_cnt == SETTLE_LAST);

   assign bus.piece_read    = cells[{bus.view_y, bus.view_x}];
   assign bus.q_piece       = cells[{bus.q_y, bus.q_x}];
   assign bus.captured      = captured_r;
   assign bus.king_captured = king_r;

   always_comb begin
      move_code = cells[src_idx];
`ifdef BOARD_STATE_PROMOTION_EN
      if (move_code == PIECE_W_PAWN && dst_idx[5:3] == 3'd0) begin
         move_code = PIECE_W_QUEEN;
      end else if (move_code == PIECE_B_PAWN && dst_idx[5:3] == 3'd7) begin
         move_code = PIECE_B_QUEEN;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= S_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_FILL:      if (fill_last) state_nxt = S_IDLE;
         S_IDLE: begin
            if (bus.init_start) begin
               state_nxt = S_FILL;
            end else if (bus.move_valid) begin
               state_nxt = S_MV_LATCH;
            end
         end
         S_MV_LATCH:  state_nxt = S_MV_WRITE;
         S_MV_WRITE:  state_nxt = (MOVE_SETTLE == 0) ? S_MV_DONE : S_MV_SETTLE;
         S_MV_SETTLE: if (settle_last) state_nxt = S_MV_DONE;
         S_MV_DONE:   state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.move_ready = (state == S_IDLE);
      bus.busy       = (state != S_IDLE);
      bus.move_done  = (state == S_MV_DONE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < 64; i++) cells[i] <= PIECE_EMPTY;
         fill_cnt      <= '0;
         settle_cnt    <= '0;
         src_idx       <= '0;
         dst_idx       <= '0;
         captured_next <= PIECE_EMPTY;
         captured_r    <= PIECE_EMPTY;
         king_r        <= 1'b0;
      end else begin
         case (state)
            S_FILL: begin
               for (int k = 0; k < FILL_PER_CYCLE; k++) cells[lay_idx[k]] <= lay_code[k];
               fill_cnt <= fill_last ? 6'd0 : fill_cnt + 6'd1;
            end
            S_IDLE: begin
               if (bus.init_start) begin
                  fill_cnt   <= '0;
                  captured_r <= PIECE_EMPTY;
                  king_r     <= 1'b0;
               end
            end
            S_MV_LATCH: begin
               src_idx       <= {bus.src_y, bus.src_x};
               dst_idx       <= {bus.dst_y, bus.dst_x};
               captured_next <= cells[{bus.dst_y, bus.dst_x}];
            end
            S_MV_WRITE: begin
               // A null move leaves the board alone and captures nothing.
               if (src_idx != dst_idx) begin
                  cells[dst_idx] <= move_code;
                  cells[src_idx] <= PIECE_EMPTY;
               end else begin
                  captured_next <= PIECE_EMPTY;
               end
               settle_cnt <= '0;
            end
            S_MV_SETTLE: settle_cnt <= settle_cnt + 2'd1;
            S_MV_DONE: begin
               captured_r <= captured_next;
               king_r     <= king_r | is_king(captured_next);
            end
            default: ;
         endcase
      end
   end

endmodule
